// File: rtl/output_compare_unit.sv
// -----------------------------------------------------------------------------
// output_compare_unit
//
// Multi-channel output-compare unit fed by a shared free-running counter.
// Every channel compares the counter against its own compare value and, on
// the first cycle of equality (a "match event"), raises a sticky flag that is
// held until acknowledged.  It also drives an output pin in one of four
// modes: flag-only, set, clear or toggle.  A second sticky bit records match
// events that arrive while the flag is still pending.  All flags are
// OR-reduced into one interrupt line.
//
// Parameters
//   WIDTH     counter / compare-value width in bits
//   CHANNELS  number of independent compare channels
//   PIN_INIT  reset level of every output pin
//
// Ports
//   iClk            in   system clock, rising edge
//   iReset_n        in   asynchronous active-low reset
//   ivCuenta        in   current counter value            [WIDTH]
//   ivCompareValue  in   packed compare values            [CHANNELS*WIDTH]
//   ivMode          in   packed pin modes (2 bits/chan)   [2*CHANNELS]
//                        00 flag-only, 01 set, 10 clear, 11 toggle
//   ivEnable        in   per-channel enable               [CHANNELS]
//   ivAck           in   per-channel acknowledge          [CHANNELS]
//   ovFlag          out  sticky match flags               [CHANNELS]
//   ovMissed        out  match-while-pending indicators   [CHANNELS]
//   ovPin           out  registered compare output pins   [CHANNELS]
//   oIrq            out  OR of all flags
// -----------------------------------------------------------------------------
module output_compare_unit #(
  parameter int   WIDTH    = 8,
  parameter int   CHANNELS = 4,
  parameter logic PIN_INIT = 1'b0
) (
  input  logic                        iClk,
  input  logic                        iReset_n,
  input  logic [WIDTH-1:0]            ivCuenta,
  input  logic [CHANNELS*WIDTH-1:0]   ivCompareValue,
  input  logic [2*CHANNELS-1:0]       ivMode,
  input  logic [CHANNELS-1:0]         ivEnable,
  input  logic [CHANNELS-1:0]         ivAck,
  output logic [CHANNELS-1:0]         ovFlag,
  output logic [CHANNELS-1:0]         ovMissed,
  output logic [CHANNELS-1:0]         ovPin,
  output logic                        oIrq
);

  localparam logic [1:0] MODE_FLAG   = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  logic [CHANNELS-1:0] eq_s;
  logic [CHANNELS-1:0] ev_s;
  logic [CHANNELS-1:0] eqDly_r;
  logic [CHANNELS-1:0] flag_r;
  logic [CHANNELS-1:0] missed_r;
  logic [CHANNELS-1:0] pin_r;

  // Full-width equality of the counter against each channel's compare value.
  always_comb begin
    eq_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      eq_s[k] = (ivCuenta == ivCompareValue[k*WIDTH +: WIDTH]);
    end
  end

  // Only the rising edge of equality counts, so a stalled counter parked on
  // the compare value yields a single event.  eqDly_r tracks equality even
  // while disabled, so enabling mid-match does not fire.
  assign ev_s = ivEnable & eq_s & ~eqDly_r;

  // Per-channel state: equality history, sticky flag, missed bit and pin.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      eqDly_r  <= '0;
      flag_r   <= '0;
      missed_r <= '0;
      pin_r    <= {CHANNELS{PIN_INIT}};
    end else begin
      eqDly_r <= eq_s;
      for (int k = 0; k < CHANNELS; k++) begin
        // An event wins over an acknowledge in the same cycle.
        if (ev_s[k]) begin
          flag_r[k] <= 1'b1;
        end else if (ivAck[k]) begin
          flag_r[k] <= 1'b0;
        end else begin
          flag_r[k] <= flag_r[k];
        end

        // Event plus ack together leaves missed untouched.
        if (ev_s[k] && flag_r[k] && !ivAck[k]) begin
          missed_r[k] <= 1'b1;
        end else if (ivAck[k] && !ev_s[k]) begin
          missed_r[k] <= 1'b0;
        end else begin
          missed_r[k] <= missed_r[k];
        end

        if (ev_s[k]) begin
          case (ivMode[2*k +: 2])
            MODE_FLAG:   pin_r[k] <= pin_r[k];
            MODE_SET:    pin_r[k] <= 1'b1;
            MODE_CLEAR:  pin_r[k] <= 1'b0;
            MODE_TOGGLE: pin_r[k] <= ~pin_r[k];
            default:     pin_r[k] <= pin_r[k];
          endcase
        end else begin
          pin_r[k] <= pin_r[k];
        end
      end
    end
  end

  assign ovFlag   = flag_r;
  assign ovMissed = missed_r;
  assign ovPin    = pin_r;
  // Interrupt is a pure function of the flag registers.
  assign oIrq     = |flag_r;

endmodule

// File: tb/tb_output_compare_unit.sv
module tb_output_compare_unit;

  logic        iClk;
  logic        iReset_n;
  logic [7:0]  ivCuenta;
  logic [31:0] ivCompareValue;
  logic [7:0]  ivMode;
  logic [3:0]  ivEnable;
  logic [3:0]  ivAck;
  logic [3:0]  ovFlag;
  logic [3:0]  ovMissed;
  logic [3:0]  ovPin;
  logic        oIrq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] flag;
    logic [3:0] missed;
    logic [3:0] pin;
    logic       irq;
    string      name;
  } exp_t;

  exp_t expQ[$];

  output_compare_unit #(.WIDTH(8), .CHANNELS(4), .PIN_INIT(1'b0)) dut (
    .iClk           (iClk),
    .iReset_n       (iReset_n),
    .ivCuenta       (ivCuenta),
    .ivCompareValue (ivCompareValue),
    .ivMode         (ivMode),
    .ivEnable       (ivEnable),
    .ivAck          (ivAck),
    .ovFlag         (ovFlag),
    .ovMissed       (ovMissed),
    .ovPin          (ovPin),
    .oIrq           (oIrq)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got flag=%b missed=%b pin=%b irq=%b, want flag=%b missed=%b pin=%b irq=%b",
               name, act[12:9], act[8:5], act[4:1], act[0], req[12:9], req[8:5], req[4:1], req[0]);
    end
  endtask

  // Monitor: outputs settle after each rising edge; pop and compare there.
  always @(posedge iClk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk(e.name, {ovFlag, ovMissed, ovPin, oIrq}, {e.flag, e.missed, e.pin, e.irq});
    end
  end

  // Drive one cycle of stimulus and queue the state expected after its edge.
  task automatic step(input logic [7:0] cnt, input logic [3:0] ack,
                      input logic [3:0] eFlag, input logic [3:0] eMissed,
                      input logic [3:0] ePin, input string name);
    exp_t e;
    @(negedge iClk);
    ivCuenta = cnt;
    ivAck    = ack;
    e.flag   = eFlag;
    e.missed = eMissed;
    e.pin    = ePin;
    e.irq    = |eFlag;
    e.name   = name;
    expQ.push_back(e);
  endtask

  task automatic do_reset(input string name);
    @(negedge iClk);
    iReset_n = 1'b0;
    ivAck    = 4'b0000;
    #2;
    chk(name, {ovFlag, ovMissed, ovPin, oIrq}, 13'b0);
    #1;
    iReset_n = 1'b1;
  endtask

  initial begin
    iReset_n       = 1'b0;
    ivCuenta       = 8'h00;
    ivCompareValue = 32'h0000_0005;
    ivMode         = 8'b0000_0001;
    ivEnable       = 4'b0001;
    ivAck          = 4'b0000;
    #12;
    chk("reset_state", {ovFlag, ovMissed, ovPin, oIrq}, 13'b0);
    iReset_n = 1'b1;

    // Single channel, set mode, compare 0x05, counter 0..0x10.
    for (int c = 0; c <= 16; c++) begin
      step(8'(c), 4'b0000, (c >= 5) ? 4'b0001 : 4'b0000, 4'b0000,
           (c >= 5) ? 4'b0001 : 4'b0000, $sformatf("set_cnt%0d", c));
    end
    step(8'h11, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "ack_clears_flag");

    // Stalled counter on 0x05: one event, ack in third cycle sticks.
    for (int i = 0; i < 10; i++) begin
      step(8'h05, (i == 2) ? 4'b0001 : 4'b0000, (i < 2) ? 4'b0001 : 4'b0000,
           4'b0000, 4'b0001, $sformatf("stall_%0d", i));
    end

    // Toggle mode at compare 0x00 across two wraps, no ack.
    do_reset("reset_before_toggle");
    ivCompareValue = 32'h0000_0000;
    ivMode         = 8'b0000_0011;
    for (int v = 16'h0FE; v <= 16'h200; v++) begin
      step(8'(v), 4'b0000, (v >= 16'h100) ? 4'b0001 : 4'b0000,
           (v >= 16'h200) ? 4'b0001 : 4'b0000,
           (v >= 16'h100 && v < 16'h200) ? 4'b0001 : 4'b0000,
           $sformatf("toggle_v%0h", v));
    end
    step(8'h01, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "ack_clears_missed");

    // Channel 1: event and ack in the same cycle.
    ivCompareValue = 32'h0000_2000;
    ivMode         = 8'b0000_0100;
    ivEnable       = 4'b0010;
    step(8'h1F, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "ch1_idle");
    step(8'h20, 4'b0010, 4'b0010, 4'b0000, 4'b0010, "ch1_ev_ack_fresh");
    step(8'h21, 4'b0010, 4'b0000, 4'b0000, 4'b0010, "ch1_ack");
    step(8'h20, 4'b0000, 4'b0010, 4'b0000, 4'b0010, "ch1_ev1");
    step(8'h21, 4'b0000, 4'b0010, 4'b0000, 4'b0010, "ch1_hold");
    step(8'h20, 4'b0000, 4'b0010, 4'b0010, 4'b0010, "ch1_missed");
    step(8'h21, 4'b0000, 4'b0010, 4'b0010, 4'b0010, "ch1_hold2");
    step(8'h20, 4'b0010, 4'b0010, 4'b0010, 4'b0010, "ch1_ev_ack_missed");
    step(8'h21, 4'b0000, 4'b0010, 4'b0010, 4'b0010, "ch1_hold3");
    step(8'h22, 4'b0010, 4'b0000, 4'b0000, 4'b0010, "ch1_ack_all");

    // Four channels: compare 3,3,7,7 with modes 00,01,10,11.
    do_reset("reset_before_multi");
    ivCompareValue = {8'h07, 8'h07, 8'h03, 8'h03};
    ivMode         = 8'b11_10_01_00;
    ivEnable       = 4'b1111;
    for (int c = 0; c <= 9; c++) begin
      step(8'(c), 4'b0000,
           (c >= 7) ? 4'b1111 : ((c >= 3) ? 4'b0011 : 4'b0000), 4'b0000,
           (c >= 7) ? 4'b1010 : ((c >= 3) ? 4'b0010 : 4'b0000),
           $sformatf("multi_cnt%0d", c));
    end
    step(8'h0A, 4'b1111, 4'b0000, 4'b0000, 4'b1010, "multi_ack");
    ivEnable = 4'b1011;
    for (int c = 0; c <= 9; c++) begin
      step(8'(c), 4'b0000,
           (c >= 7) ? 4'b1011 : ((c >= 3) ? 4'b0011 : 4'b0000), 4'b0000,
           (c >= 7) ? 4'b0010 : 4'b1010,
           $sformatf("ch2_off_cnt%0d", c));
    end

    // Asynchronous reset between edges while flags are pending.
    @(posedge iClk);
    #3;
    iReset_n = 1'b0;
    #1;
    chk("async_reset", {ovFlag, ovMissed, ovPin, oIrq}, 13'b0);
    #2;
    iReset_n = 1'b1;

    @(posedge iClk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
